// File: rtl/cgra_pkg.sv
// -----------------------------------------------------------------------------
// cgra_pkg
// Purpose : CGRA-wide constants and types used by the memory-node arbiter.
// Contents: NODES       - number of memory nodes (index NODES-1 is config node)
//           ARB_MAX_OUT - default outstanding-transaction limit of the arbiter
//           arb_id_t    - node index type
//           arb_rr_next - round-robin successor of a node index
// -----------------------------------------------------------------------------
package cgra_pkg;

  localparam int unsigned NODES       = 5;
  localparam int unsigned ARB_MAX_OUT = 4;

  typedef logic [$clog2(NODES)-1:0] arb_id_t;

  // (idx + 1) mod n without a divider.
  function automatic arb_id_t arb_rr_next(input arb_id_t idx, input int unsigned n);
    return (32'(idx) == n - 1) ? '0 : idx + arb_id_t'(1);
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// -----------------------------------------------------------------------------
// obi_pkg
// Purpose : OBI request/response structures shared by the CGRA memory nodes,
//           the node arbiter and the system-bus crossbar port.
// Contents: obi_req_t  - req, addr, we, be, wdata (master -> slave)
//           obi_resp_t - gnt, rvalid, rdata       (slave -> master)
// -----------------------------------------------------------------------------
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/arb_id_fifo.sv
// -----------------------------------------------------------------------------
// arb_id_fifo
// Purpose : in-order FIFO of node indices for granted-but-unanswered OBI
//           transactions. The head is visible combinationally (no read
//           latency) so a response can be routed in the cycle it arrives.
// Ports   : clk_i, rst_ni (synchronous, active-low)
//           push_i/data_i - write an entry (ignored when full)
//           pop_i         - drop the head (ignored when empty)
//           data_o        - current head entry
//           full_o/empty_o- occupancy flags
// -----------------------------------------------------------------------------
module arb_id_fifo #(
  parameter int unsigned DEPTH = 4,  // power of two, >= 2
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned    PtrW    = $clog2(DEPTH);
  localparam logic [PtrW:0]  FullCnt = (PtrW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PtrW+1)'(1);
        2'b01:   r_count <= r_count - (PtrW+1)'(1);
        default: r_count <= r_count;  // idle or simultaneous push/pop
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked
  // by r_count, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign full_o  = (r_count == FullCnt);
  assign empty_o = (r_count == '0);

endmodule

// File: rtl/obi_node_arbiter.sv
// -----------------------------------------------------------------------------
// obi_node_arbiter
// Purpose : shares one OBI master port between the CGRA memory nodes using
//           round-robin arbitration, with in-order response routing through
//           an ID FIFO so every rvalid returns to the node that issued it.
// Ports   : clk_i, rst_ni   - clock, synchronous active-low reset
//           nodes_req_i[]   - per-node OBI requests
//           nodes_resp_o[]  - per-node gnt / rvalid / rdata
//           bus_req_o       - request to the crossbar
//           bus_resp_i      - response from the crossbar
//           err_o           - sticky: rvalid arrived with nothing outstanding
// Macro   : STRELA_ARB_CFG_PRIO_EN - config node (NUM_REQ-1) gets strict
//           priority over the round-robin among the remaining nodes.
// -----------------------------------------------------------------------------
module obi_node_arbiter
  import obi_pkg::*, cgra_pkg::*;
#(
  parameter int unsigned NUM_REQ = NODES,        // <= NODES
  parameter int unsigned MAX_OUT = ARB_MAX_OUT   // power of two, >= 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  nodes_req_i  [NUM_REQ],
  output obi_resp_t nodes_resp_o [NUM_REQ],
  output obi_req_t  bus_req_o,
  input  obi_resp_t bus_resp_i,
  output logic      err_o
);

`ifdef STRELA_ARB_CFG_PRIO_EN
  localparam bit CfgPrio = 1'b1;
`else
  localparam bit CfgPrio = 1'b0;
`endif
  localparam arb_id_t CfgIdx = arb_id_t'(NUM_REQ - 1);

  arb_id_t r_rr;
  arb_id_t r_lock_idx;
  logic    r_lock;
  logic    r_err;

  arb_id_t w_rr_winner;
  arb_id_t w_winner;
  arb_id_t w_head;
  logic    w_rr_found;
  logic    w_any_req;
  logic    w_full;
  logic    w_empty;
  logic    w_req;
  logic    w_hs;
  logic    w_pop;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin : rr_search
    int unsigned idx;
    w_rr_winner = r_rr;
    w_rr_found  = 1'b0;
    w_any_req   = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_any_req = w_any_req | nodes_req_i[i].req;
      idx = i + 32'(r_rr);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      // With priority enabled the config node is handled outside the ring.
      if (!w_rr_found && nodes_req_i[idx].req && !(CfgPrio && idx == NUM_REQ - 1)) begin
        w_rr_found  = 1'b1;
        w_rr_winner = arb_id_t'(idx);
      end
    end
  end

  // A request left ungranted must stay on the bus unchanged until gnt.
  always_comb begin
    if (r_lock)                                      w_winner = r_lock_idx;
    else if (CfgPrio && nodes_req_i[NUM_REQ-1].req) w_winner = CfgIdx;
    else                                             w_winner = w_rr_winner;
  end

  // req deliberately ignores a same-cycle pop so it has no path from rvalid.
  assign w_req = rst_ni && w_any_req && !w_full;
  assign w_hs  = w_req && bus_resp_i.gnt;
  assign w_pop = rst_ni && bus_resp_i.rvalid && !w_empty;

  arb_id_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH ($bits(arb_id_t))
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_hs),
    .data_i  (w_winner),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_comb begin
    bus_req_o = '0;
    if (rst_ni) begin
      bus_req_o     = nodes_req_i[w_winner];
      bus_req_o.req = w_req;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      nodes_resp_o[k] = '0;
      if (rst_ni) begin
        nodes_resp_o[k].rdata  = bus_resp_i.rdata;
        nodes_resp_o[k].gnt    = w_hs && (w_winner == arb_id_t'(k));
        nodes_resp_o[k].rvalid = w_pop && (w_head == arb_id_t'(k));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_hs && !(CfgPrio && w_winner == CfgIdx)) r_rr <= arb_rr_next(w_winner, NUM_REQ);
      r_lock     <= w_req && !bus_resp_i.gnt;
      r_lock_idx <= w_winner;
      if (bus_resp_i.rvalid && w_empty) r_err <= 1'b1;
    end
  end

  assign err_o = r_err;

endmodule

// File: tb/tb_obi_node_arbiter.sv
// -----------------------------------------------------------------------------
// tb_obi_node_arbiter
// Directed scenarios followed by randomized traffic. The stimulus process
// keeps a behavioural model (pointer, outstanding-ID queue, held request) and
// queues the grant and response each cycle should produce; a monitor process
// samples the DUT on the falling edge and matches against those queues.
// -----------------------------------------------------------------------------
module tb_obi_node_arbiter;
  import obi_pkg::*;
  import cgra_pkg::*;

  localparam int NR  = NODES;
  localparam int MO  = ARB_MAX_OUT;
  localparam int CFG = NR - 1;
`ifdef STRELA_ARB_CFG_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  typedef struct {
    int          cyc;
    int          node;
    logic [31:0] data;
  } exp_t;

  logic      clk_i;
  logic      rst_ni;
  obi_req_t  nodes_req_i  [NR];
  obi_resp_t nodes_resp_o [NR];
  obi_req_t  bus_req_o;
  obi_resp_t bus_resp_i;
  logic      err_o;

  obi_node_arbiter #(.NUM_REQ(NR), .MAX_OUT(MO)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .nodes_req_i  (nodes_req_i),
    .nodes_resp_o (nodes_resp_o),
    .bus_req_o    (bus_req_o),
    .bus_resp_i   (bus_resp_i),
    .err_o        (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Node-side request state (held stable until granted).
  bit          n_act  [NR];
  logic [31:0] n_addr [NR];
  logic        n_we   [NR];
  logic [3:0]  n_be   [NR];
  logic [31:0] n_wdata[NR];

  // Bus-side stimulus.
  bit          b_gnt, b_rvalid, b_rst, rv_auto;
  int          rv_pct;
  logic [31:0] b_rdata;

  // Reference model and scoreboard.
  int       m_q[$];
  int       m_rr, m_held;
  bit       m_err;
  exp_t     gq[$];
  exp_t     rq[$];
  bit       exp_req, exp_err, in_reset, mon_en, rst_seen;
  obi_req_t exp_bus;
  int       cyc;
  int       n_vec, n_mis;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name, input int act, input int exp);
    n_vec++;
    n_mis++;
    $display("FAIL %s: got node %0d expected node %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic issue(input int k, input logic [31:0] a, input logic w);
    if (!n_act[k]) begin
      n_act[k]   = 1'b1;
      n_addr[k]  = a;
      n_we[k]    = w;
      n_be[k]    = 4'($urandom);
      n_wdata[k] = $urandom;
    end
  endtask

  // Winner by the arbitration rules: held request, then config priority,
  // then first requester scanning upward from the pointer with wrap.
  function automatic int model_pick();
    if (m_held >= 0) return m_held;
    if (PRIO && n_act[CFG]) return CFG;
    for (int i = 0; i < NR; i++) begin
      int idx;
      idx = (m_rr + i) % NR;
      if (!(PRIO && idx == CFG) && n_act[idx]) return idx;
    end
    return 0;
  endfunction

  // Applies one clock cycle of stimulus; returns just after the next edge.
  task automatic tick();
    int w;
    bit any, hs;
    if (rst_seen) check("rr_q", dut.r_rr, m_rr);
    cyc++;
    if (rv_auto) b_rvalid = (m_q.size() > 0) && ($urandom_range(99) < rv_pct);
    for (int k = 0; k < NR; k++) begin
      nodes_req_i[k].req   = n_act[k];
      nodes_req_i[k].addr  = n_addr[k];
      nodes_req_i[k].we    = n_we[k];
      nodes_req_i[k].be    = n_be[k];
      nodes_req_i[k].wdata = n_wdata[k];
    end
    bus_resp_i.gnt    = b_gnt;
    bus_resp_i.rvalid = b_rvalid;
    bus_resp_i.rdata  = b_rdata;
    rst_ni            = b_rst;
    if (!b_rst) begin
      in_reset = 1'b1;
      exp_req  = 1'b0;
      m_q.delete();
      m_rr     = 0;
      m_held   = -1;
      m_err    = 1'b0;
      rst_seen = 1'b1;
    end else begin
      in_reset = 1'b0;
      exp_err  = m_err;
      any = 1'b0;
      for (int k = 0; k < NR; k++) any |= n_act[k];
      w = model_pick();
      exp_req       = any && (m_q.size() < MO);
      exp_bus.req   = exp_req;
      exp_bus.addr  = n_addr[w];
      exp_bus.we    = n_we[w];
      exp_bus.be    = n_be[w];
      exp_bus.wdata = n_wdata[w];
      hs = exp_req && b_gnt;
      if (hs) gq.push_back('{cyc, w, n_addr[w]});
      if (b_rvalid) begin
        if (m_q.size() > 0) begin
          rq.push_back('{cyc, m_q[0], b_rdata});
          void'(m_q.pop_front());
        end else begin
          m_err = 1'b1;
        end
      end
      if (hs) begin
        m_q.push_back(w);
        if (!(PRIO && w == CFG)) m_rr = (w + 1) % NR;
        n_act[w] = 1'b0;
      end
      m_held = (exp_req && !b_gnt) ? w : -1;
    end
    mon_en = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    b_gnt   = 1'b0;
    rv_auto = 1'b1;
    rv_pct  = 100;
    for (int i = 0; i < 2 * MO && m_q.size() > 0; i++) tick();
  endtask

  // Monitor: compares the sampled DUT outputs with the queued expectations.
  task automatic monitor_cycle();
    int   ng, gi, nr, ri;
    exp_t e;
    if (in_reset) begin
      check("rst_bus_req", bus_req_o, '0);
      for (int k = 0; k < NR; k++) check("rst_node_resp", nodes_resp_o[k], '0);
      return;
    end
    check("bus_req", bus_req_o.req, exp_req);
    if (exp_req) check("bus_fields", bus_req_o, exp_bus);
    check("err_o", err_o, exp_err);
    while (gq.size() > 0 && gq[0].cyc < cyc) begin
      miss("gnt_missing", -1, gq[0].node);
      void'(gq.pop_front());
    end
    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      miss("rvalid_missing", -1, rq[0].node);
      void'(rq.pop_front());
    end
    ng = 0; gi = -1; nr = 0; ri = -1;
    for (int k = 0; k < NR; k++) begin
      if (nodes_resp_o[k].gnt === 1'b1)    begin ng++; gi = k; end
      if (nodes_resp_o[k].rvalid === 1'b1) begin nr++; ri = k; end
    end
    if (ng > 0) begin
      if (gq.size() == 0 || gq[0].cyc != cyc) miss("gnt_unexpected", gi, -1);
      else begin
        e = gq.pop_front();
        check("gnt_node", gi, e.node);
        check("gnt_onehot", ng, 1);
      end
    end
    if (nr > 0) begin
      if (rq.size() == 0 || rq[0].cyc != cyc) miss("rvalid_unexpected", ri, -1);
      else begin
        e = rq.pop_front();
        check("rvalid_node", ri, e.node);
        check("rvalid_onehot", nr, 1);
        check("rdata", nodes_resp_o[ri].rdata, e.data);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (mon_en) monitor_cycle();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0;
    bus_resp_i = '0;
    for (int k = 0; k < NR; k++) begin
      nodes_req_i[k] = '0;
      n_act[k] = 1'b0; n_addr[k] = '0; n_we[k] = 1'b0; n_be[k] = '0; n_wdata[k] = '0;
    end
    b_gnt = 0; b_rvalid = 0; b_rdata = '0; rv_auto = 0; rv_pct = 0;
    m_rr = 0; m_held = -1; m_err = 0; cyc = 0; n_vec = 0; n_mis = 0;
    mon_en = 0; rst_seen = 0; in_reset = 1; exp_req = 0; exp_err = 0; exp_bus = '0;
    @(posedge clk_i);
    #1;

    // Reset
    b_rst = 1'b0;
    tick(); tick();
    b_rst = 1'b1;

    // Single requester: node 2 reads 0x100 and 0x104
    b_gnt = 1'b1;
    issue(2, 32'h100, 1'b0); tick();
    issue(2, 32'h104, 1'b0); tick();
    b_gnt = 1'b0; b_rvalid = 1'b1; b_rdata = 32'hAAAA; tick();
    b_rdata = 32'hBBBB; tick();
    b_rvalid = 1'b0; tick();
    check("single_err", err_o, 1'b0);

    // Fairness: nodes 0, 1, 3 contend, gnt always high
    b_rst = 1'b0; tick(); b_rst = 1'b1;
    b_gnt = 1'b1; rv_auto = 1'b1; rv_pct = 100;
    for (int i = 0; i < 6; i++) begin
      issue(0, 32'h1000, 1'b0);
      issue(1, 32'h1100, 1'b1);
      issue(3, 32'h1300, 1'b0);
      tick();
    end
    check("rr_after_six", dut.r_rr, 4);
    repeat (4) tick();
    drain();

    // Lock: node 1 held with gnt low while node 0 joins
    b_gnt = 1'b0; rv_pct = 0;
    issue(1, 32'h200, 1'b0); tick();
    check("lock_addr0", bus_req_o.addr, 32'h200);
    issue(0, 32'h300, 1'b1); tick();
    check("lock_addr1", bus_req_o.addr, 32'h200);
    tick();
    check("lock_addr2", bus_req_o.addr, 32'h200);
    b_gnt = 1'b1; tick();
    tick();
    check("lock_rr_after_node0", dut.r_rr, 1);
    drain();

    // Outstanding limit
    b_gnt = 1'b1; rv_pct = 0;
    for (int k = 0; k < 4; k++) issue(k, 32'h400 + 32'(16 * k), 1'(k));
    repeat (4) tick();
    issue(2, 32'h500, 1'b0); tick();
    check("full_req_low", bus_req_o.req, 1'b0);
    rv_pct = 100; tick();
    check("req_after_pop", bus_req_o.req, 1'b1);
    tick();
    drain();

    // Spurious response, reset flushes FIFO and error
    rv_auto = 1'b0; b_gnt = 1'b0; b_rvalid = 1'b1; b_rdata = 32'hDEAD; tick();
    check("err_set", err_o, 1'b1);
    b_rvalid = 1'b0; b_gnt = 1'b1; issue(3, 32'h600, 1'b0); tick();
    b_gnt = 1'b0; b_rst = 1'b0; tick(); b_rst = 1'b1;
    check("err_cleared", err_o, 1'b0);
    check("rr_reset", dut.r_rr, 0);
    b_rvalid = 1'b1; b_rdata = 32'hBEEF; tick();
    check("err_after_flush", err_o, 1'b1);
    b_rvalid = 1'b0; b_rst = 1'b0; tick(); b_rst = 1'b1;
    rv_auto = 1'b1;

`ifdef STRELA_ARB_CFG_PRIO_EN
    // Config node priority
    b_gnt = 1'b1; rv_pct = 100;
    for (int i = 0; i < 6; i++) begin
      issue(CFG, 32'h700, 1'b1);
      issue(0, 32'h800, 1'b0);
      tick();
    end
    check("prio_rr_unchanged", dut.r_rr, 0);
    tick();
    check("prio_rr_after_node0", dut.r_rr, 1);
    drain();
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NR; k++)
        if (!n_act[k] && $urandom_range(99) < 30)
          issue(k, $urandom & 32'h0000_FFFC, 1'($urandom_range(1)));
      b_gnt   = ($urandom_range(99) < 70);
      rv_auto = 1'b1;
      rv_pct  = 50;
      b_rdata = $urandom;
      b_rst   = ($urandom_range(499) != 0);
      tick();
    end
    b_rst = 1'b1;
    for (int k = 0; k < NR; k++) n_act[k] = 1'b0;
    drain();

    @(negedge clk_i);
    #1;
    while (gq.size() > 0) begin
      miss("gnt_never_seen", -1, gq[0].node);
      void'(gq.pop_front());
    end
    while (rq.size() > 0) begin
      miss("rvalid_never_seen", -1, rq[0].node);
      void'(rq.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
